fxp_dot_sequencer: RTL and testbench

- Sequences the signed fixed-point multiply datapath over a streamed operand pair vector and accumulates a saturated Q-format dot product.
- Sits between an operand source (e.g. weight/activation buffers) and a consumer such as a neuron/activation stage.
- Contains one registered multiply stage, with round-half-up and saturation, and one saturating accumulator stage.
- Controlled by a start/length command; the result is returned on a valid/ready port.

---
 rtl/fxp_dot_sequencer.sv | 99 +++++++++
 tb/tb_fxp_dot_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fxp_dot_sequencer.sv
// fxp_dot_sequencer: streams signed Q-format operand pairs through a rounding/saturating
// multiply stage and a saturating accumulator, returning the dot product on a valid/ready port.
module fxp_dot_sequencer #(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 16,
    parameter int LEN_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [LEN_W-1:0]        len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_a,
    input  logic signed [WIDTH-1:0] in_b,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [WIDTH-1:0] res_data,
    output logic                    sat_flag,
    output logic                    busy
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic signed [2*WIDTH-1:0] MAX_L = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH-1:0] MIN_L = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic signed [2*WIDTH-1:0] RND   = {{(2*WIDTH-1){1'b0}}, 1'b1} << (FRAC_BITS-1);
    localparam logic [WIDTH-1:0]          MAX_W = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]          MIN_W = {1'b1, {(WIDTH-1){1'b0}}};

    state_t                    state, state_next;
    logic [LEN_W-1:0]          len_q, cnt;
    logic signed [WIDTH-1:0]   acc, p_reg, prod, acc_next;
    logic                      p_vld, accept, prod_sat, acc_ovf;
    logic signed [2*WIDTH-1:0] a_ext, b_ext, full, shifted;
    logic [WIDTH:0]            sum;

    assign accept   = in_valid && in_ready;
    assign in_ready = (state == RUN) && (cnt < len_q);
    assign busy     = state != IDLE;

    // Operands are sign-extended so the double-width product is exact.
    assign a_ext    = {{WIDTH{in_a[WIDTH-1]}}, in_a};
    assign b_ext    = {{WIDTH{in_b[WIDTH-1]}}, in_b};
    assign full     = a_ext * b_ext;
    assign shifted  = (full + RND) >>> FRAC_BITS;
    assign prod_sat = (shifted > MAX_L) || (shifted < MIN_L);
    assign prod     = prod_sat ? (shifted[2*WIDTH-1] ? MIN_W : MAX_W) : shifted[WIDTH-1:0];

    // One guard bit: overflow whenever the two top bits of the sum disagree.
    assign sum      = {acc[WIDTH-1], acc} + {p_reg[WIDTH-1], p_reg};
    assign acc_ovf  = sum[WIDTH] != sum[WIDTH-1];
    assign acc_next = acc_ovf ? (sum[WIDTH] ? MIN_W : MAX_W) : sum[WIDTH-1:0];

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? ((len == '0) ? DONE : RUN) : IDLE;
            RUN:     state_next = (accept && (cnt + LEN_W'(1) == len_q)) ? DRAIN : RUN;
            DRAIN:   state_next = DONE;
            DONE:    state_next = (res_valid && res_ready) ? IDLE : DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            len_q     <= '0;
            cnt       <= '0;
            acc       <= '0;
            p_reg     <= '0;
            p_vld     <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            sat_flag  <= 1'b0;
        end else begin
            state     <= state_next;
            p_vld     <= accept;
            res_valid <= (state == DONE) && !(res_valid && res_ready);
            if (accept)
                p_reg <= prod;
            if (state == IDLE && start) begin
                len_q    <= len;
                cnt      <= '0;
                acc      <= '0;
                sat_flag <= 1'b0;
                res_data <= '0;
            end else begin
                if (accept)
                    cnt <= cnt + LEN_W'(1);
                if (p_vld)
                    acc <= acc_next;
                sat_flag <= sat_flag | (accept && prod_sat) | (p_vld && acc_ovf);
                if (state == DRAIN)
                    res_data <= p_vld ? acc_next : acc;
            end
        end
    end
endmodule

// File: tb/tb_fxp_dot_sequencer.sv
// tb_fxp_dot_sequencer: directed Q16.16 vectors with hand-computed results for fxp_dot_sequencer.
module tb_fxp_dot_sequencer;
    logic        clk = 1'b0;
    logic        rst_n, start, in_valid, in_ready, res_valid, res_ready, sat_flag, busy;
    logic [15:0] len;
    logic [31:0] in_a, in_b, res_data;
    int          total = 0;
    int          bad = 0;
    int          accepts;

    fxp_dot_sequencer #(.WIDTH(32), .FRAC_BITS(16), .LEN_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .sat_flag(sat_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic start_job(input logic [15:0] n);
        start = 1'b1;
        len   = n;
        tick();
        start = 1'b0;
        len   = 16'hFFFF;
    endtask

    task automatic feed(input logic [31:0] a, input logic [31:0] b);
        in_a = a;
        in_b = b;
        for (int k = 0; k < 20 && !in_ready; k++) tick();
        check("feed_rdy", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic [31:0] exp_data, input logic exp_sat);
        for (int k = 0; k < 20 && !res_valid; k++) tick();
        check({tag, "_vld"}, {31'd0, res_valid}, 32'd1);
        check({tag, "_data"}, res_data, exp_data);
        check({tag, "_sat"}, {31'd0, sat_flag}, {31'd0, exp_sat});
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, "_vclr"}, {31'd0, res_valid}, 32'd0);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic job1(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_data, input logic exp_sat);
        start_job(16'd1);
        feed(a, b);
        get_result(tag, exp_data, exp_sat);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rdy"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_rv"}, {31'd0, res_valid}, 32'd0);
        check({tag, "_rd"}, res_data, 32'd0);
        check({tag, "_sat"}, {31'd0, sat_flag}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
        in_a = '0; in_b = '0; res_ready = 1'b0;
        tick();
        tick();
        check_reset("rst");
        rst_n = 1'b1;
        tick();

        // 1.5*2.0 + 2.0*(-0.5) = 2.0, result two cycles after the last accept edge
        start_job(16'd2);
        check("run_rdy", {31'd0, in_ready}, 32'd1);
        feed(32'h00018000, 32'h00020000);
        feed(32'h00020000, 32'hFFFF8000);
        check("drain_rdy", {31'd0, in_ready}, 32'd0);
        check("lat0", {31'd0, res_valid}, 32'd0);
        tick();
        check("lat1", {31'd0, res_valid}, 32'd0);
        tick();
        check("lat2", {31'd0, res_valid}, 32'd1);
        get_result("basic", 32'h00020000, 1'b0);

        job1("rnd_pos", 32'h00000001, 32'h00008000, 32'h00000001, 1'b0);
        job1("rnd_neg", 32'hFFFFFFFF, 32'h00008000, 32'h00000000, 1'b0);
        job1("psat_pos", 32'h7FFF0000, 32'h7FFF0000, 32'h7FFFFFFF, 1'b1);
        job1("psat_neg", 32'h7FFF0000, 32'h80000000, 32'h80000000, 1'b1);

        start_job(16'd2);
        feed(32'h00800000, 32'h00800000);
        feed(32'h00800000, 32'h00800000);
        get_result("asat", 32'h7FFFFFFF, 1'b1);

        // gapped input with a stray start in RUN; four 1.0*1.0 terms give 4.0
        start_job(16'd4);
        accepts = 0;
        in_a = 32'h00010000;
        in_b = 32'h00010000;
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 0);
            start    = (i == 1);
            len      = 16'd1;
            if (in_valid && in_ready) accepts++;
            tick();
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check("fc_accepts", accepts, 32'd4);
        check("fc_rdy_low", {31'd0, in_ready}, 32'd0);
        for (int k = 0; k < 20 && !res_valid; k++) tick();
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            len   = 16'd0;
            check("hold_vld", {31'd0, res_valid}, 32'd1);
            check("hold_data", res_data, 32'h00040000);
            tick();
        end
        start = 1'b0;
        get_result("fc", 32'h00040000, 1'b0);

        start_job(16'd0);
        check("len0_rdy", {31'd0, in_ready}, 32'd0);
        check("len0_busy", {31'd0, busy}, 32'd1);
        tick();
        check("len0_rdy2", {31'd0, in_ready}, 32'd0);
        get_result("len0", 32'h00000000, 1'b0);

        // abort a job that has already saturated, then confirm a clean restart
        start_job(16'd4);
        feed(32'h7FFF0000, 32'h7FFF0000);
        feed(32'h7FFF0000, 32'h7FFF0000);
        check("pre_rst_sat", {31'd0, sat_flag}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset("mid_rst");
        tick();
        job1("after_rst", 32'h00010000, 32'h00010000, 32'h00010000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
